mac_seq_ctrl: RTL

Sequencing controller for the 16-bit MAC unit. It accepts unsigned 16×16 operand pairs over a valid/ready handshake and forms the 32-bit product. It then accumulates the product into a wide accumulator nibble-serially, reusing a single 4-bit carry-select adder slice over successive cycles. It sits between the operand source and the accumulator consumer and owns all time-sharing of the adder slice.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_seq_ctrl_if.sv | 24 ++
 rtl/adder_4bit.sv | 31 +++
 rtl/mac_seq_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and FSM state type for the MAC sequencing controller
package mac_pkg;

  localparam int OPND_W = 16;
  localparam int PROD_W = 32;
  localparam int NIB_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } mac_state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - operand handshake and accumulator result bundle
interface mac_seq_ctrl_if #(
  parameter int ACC_W = 40
);
  import mac_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] in_a;
  logic [OPND_W-1:0] in_b;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, acc_out, out_valid
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, acc_out, out_valid
  );

endinterface

// File: rtl/adder_4bit.sv
// rtl/adder_4bit.sv - 4-bit carry-select adder slice
// Low pair ripples; the high pair is precomputed for both carries and selected.
module adder_4bit
  import mac_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [2:0] lo_sum;
  logic [2:0] hi_sum0;
  logic [2:0] hi_sum1;

  always_comb begin
    lo_sum  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, ci};
    hi_sum0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    hi_sum1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    s[1:0]  = lo_sum[1:0];
    if (lo_sum[2]) begin
      s[3:2] = hi_sum1[1:0];
      co     = hi_sum1[2];
    end else begin
      s[3:2] = hi_sum0[1:0];
      co     = hi_sum0[2];
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - nibble-serial multiply-accumulate sequencer around one 4-bit adder slice
// Optional MAC_SATURATE_EN: clamp the accumulator to all ones on overflow.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  output logic            busy,
  output logic            ovf,
  mac_seq_ctrl_if.slave   bus
);

  localparam int NIB   = ACC_W / NIB_W;
  localparam int IDX_W = $clog2(NIB);

  mac_state_t        state_q;
  mac_state_t        state_d;

  logic [OPND_W-1:0] a_q;
  logic [OPND_W-1:0] b_q;
  logic [ACC_W-1:0]  prod_q;
  logic [ACC_W-1:0]  acc_q;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic              ovf_q;

  logic              in_ready_c;
  logic              out_valid_c;
  logic              busy_c;
  logic              last_step;
  logic [PROD_W-1:0] mul_c;
  logic [NIB_W-1:0]  acc_nib;
  logic [NIB_W-1:0]  prod_nib;
  logic [NIB_W-1:0]  sum_nib;
  logic              sum_co;

  assign last_step = (idx_q == IDX_W'(NIB - 1));
  assign mul_c     = PROD_W'(a_q) * PROD_W'(b_q);
  assign acc_nib   = acc_q[NIB_W*idx_q +: NIB_W];
  assign prod_nib  = prod_q[NIB_W*idx_q +: NIB_W];

  adder_4bit u_adder (
    .a  (acc_nib),
    .b  (prod_nib),
    .ci (carry_q),
    .s  (sum_nib),
    .co (sum_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend on state only, so nothing combinational reaches them from inputs.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.in_valid) begin
          state_d = MUL;
        end
      end
      MUL: begin
        state_d = ACC;
      end
      ACC: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
          if (bus.in_valid) begin
            a_q <= bus.in_a;
            b_q <= bus.in_b;
          end
        end
        MUL: begin
          prod_q  <= ACC_W'(mul_c);
          idx_q   <= '0;
          carry_q <= 1'b0;
        end
        ACC: begin
          acc_q[NIB_W*idx_q +: NIB_W] <= sum_nib;
          carry_q                     <= sum_co;
          idx_q                       <= idx_q + IDX_W'(1);
          if (last_step && sum_co) begin
            ovf_q <= 1'b1;
`ifdef MAC_SATURATE_EN
            acc_q <= '1;
`else
            acc_q[NIB_W*idx_q +: NIB_W] <= sum_nib;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.acc_out   = acc_q;
  assign busy          = busy_c;
  assign ovf           = ovf_q;

endmodule
